// File: rtl/ap_handshake_profiler.sv
// ap_handshake_profiler: watches one ap_ctrl_hs block and emits one record per
// completed transaction {start cycle, latency, interval since previous start}
// through a first-word fall-through record FIFO.
// Record handshake: a record transfers on a rising ap_clk edge when rec_valid and
// rec_ready are both high; rec_* hold the head record steady while rec_valid is
// high and read as zero while the FIFO is empty.
module ap_handshake_profiler #(
  parameter int CNT_W    = 32,
  parameter int TS_DEPTH = 4,
  parameter int DEPTH    = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        mon_ap_start,
  input  logic                        mon_ap_ready,
  input  logic                        mon_ap_done,
  input  logic                        mon_ap_continue,
  output logic                        rec_valid,
  input  logic                        rec_ready,
  output logic [CNT_W-1:0]            rec_start,
  output logic [CNT_W-1:0]            rec_latency,
  output logic [CNT_W-1:0]            rec_interval,
  output logic [$clog2(DEPTH):0]      rec_level,
  output logic [15:0]                 drop_count,
  output logic [$clog2(TS_DEPTH):0]   inflight,
  output logic                        orphan_err,
  output logic                        ts_ovf
);

  localparam int TA = $clog2(TS_DEPTH);
  localparam int OA = $clog2(DEPTH);

  // free-running cycle counter and start-detection state
  logic [CNT_W-1:0] cyc_q;
  logic             pend_q;
  logic [CNT_W-1:0] prev_start_q;
  logic             have_prev_q;

  // timestamp FIFO (open transactions)
  logic [CNT_W-1:0] ts_start_mem [TS_DEPTH];
  logic [CNT_W-1:0] ts_int_mem   [TS_DEPTH];
  logic [TA-1:0]    ts_wr_q, ts_rd_q;
  logic [TA:0]      ts_cnt_q;

  // record FIFO
  logic [CNT_W-1:0] rec_s_mem [DEPTH];
  logic [CNT_W-1:0] rec_l_mem [DEPTH];
  logic [CNT_W-1:0] rec_i_mem [DEPTH];
  logic [OA-1:0]    rec_wr_q, rec_rd_q;
  logic [OA:0]      rec_cnt_q;

  logic [15:0]      drop_q;
  logic             orphan_q;
  logic             ovf_q;

  logic             start_ev, done_ev;
  logic             ts_empty, ts_full, rec_full, rec_pop;
  logic [CNT_W-1:0] interval_now;
  logic             ts_push, ts_pop, rec_push, rec_store, rec_drop;
  logic             start_taken, orphan_set, ovf_set;
  logic [CNT_W-1:0] rec_s_d, rec_l_d, rec_i_d;

  assign start_ev     = enable & mon_ap_start & ~pend_q;
  assign done_ev      = enable & mon_ap_done & mon_ap_continue;
  assign ts_empty     = (ts_cnt_q == '0);
  assign ts_full      = (ts_cnt_q == (TA+1)'(TS_DEPTH));
  assign rec_full     = (rec_cnt_q == (OA+1)'(DEPTH));
  assign rec_valid    = (rec_cnt_q != '0);
  assign rec_pop      = rec_valid & rec_ready;
  assign interval_now = have_prev_q ? (cyc_q - prev_start_q) : '0;
  assign rec_store    = rec_push & (~rec_full | rec_pop);
  assign rec_drop     = rec_push & rec_full & ~rec_pop;

  // decide what this cycle's start/done events do to both FIFOs
  always_comb begin
    ts_push     = 1'b0;
    ts_pop      = 1'b0;
    rec_push    = 1'b0;
    start_taken = 1'b0;
    orphan_set  = 1'b0;
    ovf_set     = 1'b0;
    rec_s_d     = '0;
    rec_l_d     = '0;
    rec_i_d     = '0;
    if (done_ev && !ts_empty) begin
      ts_pop   = 1'b1;
      rec_push = 1'b1;
      rec_s_d  = ts_start_mem[ts_rd_q];
      rec_l_d  = cyc_q - ts_start_mem[ts_rd_q];
      rec_i_d  = ts_int_mem[ts_rd_q];
    end else if (done_ev && start_ev) begin
      // zero-latency bypass: the start is consumed directly by the done
      rec_push    = 1'b1;
      rec_s_d     = cyc_q;
      rec_i_d     = interval_now;
      start_taken = 1'b1;
    end else if (done_ev) begin
      orphan_set = 1'b1;
    end
    // fullness is judged before this cycle's pop
    if (start_ev && !(done_ev && ts_empty)) begin
      if (ts_full) begin
        ovf_set = 1'b1;
      end else begin
        ts_push     = 1'b1;
        start_taken = 1'b1;
      end
    end
  end

  // control state: counters, pointers, sticky flags; clear acts like reset
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cyc_q        <= '0;
      pend_q       <= 1'b0;
      prev_start_q <= '0;
      have_prev_q  <= 1'b0;
      ts_wr_q      <= '0;
      ts_rd_q      <= '0;
      ts_cnt_q     <= '0;
      rec_wr_q     <= '0;
      rec_rd_q     <= '0;
      rec_cnt_q    <= '0;
      drop_q       <= '0;
      orphan_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (clear) begin
      cyc_q        <= '0;
      pend_q       <= 1'b0;
      prev_start_q <= '0;
      have_prev_q  <= 1'b0;
      ts_wr_q      <= '0;
      ts_rd_q      <= '0;
      ts_cnt_q     <= '0;
      rec_wr_q     <= '0;
      rec_rd_q     <= '0;
      rec_cnt_q    <= '0;
      drop_q       <= '0;
      orphan_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (mon_ap_ready)  pend_q <= 1'b0;
      else if (start_ev) pend_q <= 1'b1;
      if (start_taken) begin
        prev_start_q <= cyc_q;
        have_prev_q  <= 1'b1;
      end
      if (ts_push) ts_wr_q <= ts_wr_q + TA'(1);
      if (ts_pop)  ts_rd_q <= ts_rd_q + TA'(1);
      ts_cnt_q <= ts_cnt_q + (TA+1)'(ts_push) - (TA+1)'(ts_pop);
      if (rec_store) rec_wr_q <= rec_wr_q + OA'(1);
      if (rec_pop)   rec_rd_q <= rec_rd_q + OA'(1);
      rec_cnt_q <= rec_cnt_q + (OA+1)'(rec_store) - (OA+1)'(rec_pop);
      if (rec_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (orphan_set) orphan_q <= 1'b1;
      if (ovf_set)    ovf_q    <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while their slots are empty
  always_ff @(posedge ap_clk) begin
    if (ts_push) begin
      ts_start_mem[ts_wr_q] <= cyc_q;
      ts_int_mem[ts_wr_q]   <= interval_now;
    end
    if (rec_store) begin
      rec_s_mem[rec_wr_q] <= rec_s_d;
      rec_l_mem[rec_wr_q] <= rec_l_d;
      rec_i_mem[rec_wr_q] <= rec_i_d;
    end
  end

  assign rec_start    = rec_valid ? rec_s_mem[rec_rd_q] : '0;
  assign rec_latency  = rec_valid ? rec_l_mem[rec_rd_q] : '0;
  assign rec_interval = rec_valid ? rec_i_mem[rec_rd_q] : '0;
  assign rec_level    = rec_cnt_q;
  assign inflight     = ts_cnt_q;
  assign drop_count   = drop_q;
  assign orphan_err   = orphan_q;
  assign ts_ovf       = ovf_q;

endmodule

// File: tb/tb_ap_handshake_profiler.sv
// Bench for ap_handshake_profiler: directed scenarios followed by random traffic,
// every cycle compared against a queue-based transaction model.
module tb_ap_handshake_profiler;

  localparam int CNT_W    = 8;
  localparam int TS_DEPTH = 4;
  localparam int DEPTH    = 16;

  // clock / reset / DUT signals
  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             enable, clear;
  logic             mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue;
  logic             rec_valid, rec_ready;
  logic [CNT_W-1:0] rec_start, rec_latency, rec_interval;
  logic [4:0]       rec_level;
  logic [15:0]      drop_count;
  logic [2:0]       inflight;
  logic             orphan_err, ts_ovf;

  always #5 ap_clk = ~ap_clk;

  ap_handshake_profiler #(.CNT_W(CNT_W), .TS_DEPTH(TS_DEPTH), .DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .clear(clear),
    .mon_ap_start(mon_ap_start), .mon_ap_ready(mon_ap_ready),
    .mon_ap_done(mon_ap_done), .mon_ap_continue(mon_ap_continue),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_start(rec_start), .rec_latency(rec_latency), .rec_interval(rec_interval),
    .rec_level(rec_level), .drop_count(drop_count), .inflight(inflight),
    .orphan_err(orphan_err), .ts_ovf(ts_ovf)
  );

  // reference model: open transactions and stored records as queues
  typedef struct { logic [CNT_W-1:0] s; logic [CNT_W-1:0] iv; } open_t;
  typedef struct { logic [CNT_W-1:0] s; logic [CNT_W-1:0] lat; logic [CNT_W-1:0] iv; } rec_t;
  open_t            open_q[$];
  rec_t             exp_q[$];
  logic [CNT_W-1:0] m_cyc, m_prev;
  logic             m_have_prev, m_pend, m_orphan, m_ovf;
  int               m_drop;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    open_q.delete();
    exp_q.delete();
    m_cyc = '0; m_prev = '0; m_have_prev = 1'b0; m_pend = 1'b0;
    m_orphan = 1'b0; m_ovf = 1'b0; m_drop = 0;
  endtask

  // one rising edge of behaviour, from the transaction rules
  task automatic model_edge();
    logic start, done, have_rec;
    logic [CNT_W-1:0] iv;
    int n_open;
    rec_t r;
    open_t h, o;
    if (!ap_rst_n || clear) begin
      model_reset();
    end else begin
      start    = enable && mon_ap_start && !m_pend;
      done     = enable && mon_ap_done && mon_ap_continue;
      iv       = m_have_prev ? m_cyc - m_prev : '0;
      n_open   = open_q.size();
      have_rec = 1'b0;
      if (done && n_open > 0) begin
        h = open_q.pop_front();
        r.s = h.s; r.lat = m_cyc - h.s; r.iv = h.iv; have_rec = 1'b1;
      end
      if (start) begin
        if (done && n_open == 0) begin
          r.s = m_cyc; r.lat = '0; r.iv = iv; have_rec = 1'b1;
          m_prev = m_cyc; m_have_prev = 1'b1;
        end else if (n_open == TS_DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          o.s = m_cyc; o.iv = iv; open_q.push_back(o);
          m_prev = m_cyc; m_have_prev = 1'b1;
        end
      end else if (done && n_open == 0) begin
        m_orphan = 1'b1;
      end
      if (mon_ap_ready) m_pend = 1'b0;
      else if (start)   m_pend = 1'b1;
      if (rec_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (have_rec) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else if (m_drop < 65535) m_drop++;
      end
      m_cyc = m_cyc + 1'b1;
    end
  endtask

  // scoreboard: all outputs against the model
  task automatic check_all();
    rec_t hd;
    hd.s = '0; hd.lat = '0; hd.iv = '0;
    if (exp_q.size() > 0) hd = exp_q[0];
    chk("rec_valid",    rec_valid,    exp_q.size() > 0);
    chk("rec_start",    rec_start,    hd.s);
    chk("rec_latency",  rec_latency,  hd.lat);
    chk("rec_interval", rec_interval, hd.iv);
    chk("rec_level",    rec_level,    exp_q.size());
    chk("drop_count",   drop_count,   m_drop);
    chk("inflight",     inflight,     open_q.size());
    chk("orphan_err",   orphan_err,   m_orphan);
    chk("ts_ovf",       ts_ovf,       m_ovf);
  endtask

  // driver tasks: inputs change at negedge, sampled at posedge
  task automatic step();
    @(posedge ap_clk);
    model_edge();
    @(negedge ap_clk);
    check_all();
  endtask

  task automatic set_in(input logic st, input logic rd, input logic dn, input logic ct);
    mon_ap_start = st; mon_ap_ready = rd; mon_ap_done = dn; mon_ap_continue = ct;
  endtask

  task automatic idle_until(input logic [CNT_W-1:0] c);
    int n = 0;
    set_in(0, 0, 0, 0);
    while (m_cyc != c && n < 400) begin step(); n++; end
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    int iv_exp[3];
    iv_exp = '{0, 1, 1};
    ap_rst_n = 1'b0; enable = 1'b1; clear = 1'b0; rec_ready = 1'b0;
    set_in(0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge ap_clk);
    check_all();
    ap_rst_n = 1'b1;

    // single transaction: start 10..14, ready+done at 14
    idle_until(8'd10);
    set_in(1, 0, 0, 0); repeat (4) step();
    set_in(1, 1, 1, 1); step();
    set_in(0, 0, 0, 0);
    chk("t1_valid", rec_valid, 1);
    chk("t1_start", rec_start, 10);
    chk("t1_lat", rec_latency, 4);
    chk("t1_iv", rec_interval, 0);
    rec_ready = 1'b1; step(); rec_ready = 1'b0;

    // II=1 pipeline
    do_clear();
    idle_until(8'd20);
    set_in(1, 1, 0, 0); repeat (3) step();
    chk("t2_inflight", inflight, 3);
    idle_until(8'd25);
    set_in(0, 0, 1, 1); repeat (3) step();
    set_in(0, 0, 0, 0);
    chk("t2_level", rec_level, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_start", rec_start, 20 + i);
      chk("t2_lat", rec_latency, 5);
      chk("t2_iv", rec_interval, iv_exp[i]);
      rec_ready = 1'b1; step(); rec_ready = 1'b0;
    end

    // backpressure: 20 transactions into a 16-deep FIFO
    do_clear();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 1, 0, 0); step();
      set_in(0, 0, 1, 1); step();
    end
    set_in(0, 0, 0, 0);
    chk("t3_level", rec_level, 16);
    chk("t3_drop", drop_count, 4);
    chk("t3_head", rec_start, 0);
    set_in(1, 1, 0, 0); step();
    set_in(0, 0, 1, 1); rec_ready = 1'b1; step();
    set_in(0, 0, 0, 0); rec_ready = 1'b0;
    chk("t3_full_pop_level", rec_level, 16);
    chk("t3_full_pop_drop", drop_count, 4);
    chk("t3_head2", rec_start, 2);
    rec_ready = 1'b1; repeat (16) step(); rec_ready = 1'b0;
    chk("t3_drained", rec_level, 0);

    // orphan done
    do_clear();
    set_in(0, 0, 1, 1); step(); set_in(0, 0, 0, 0);
    chk("t4_orphan", orphan_err, 1);
    chk("t4_norec", rec_valid, 0);
    // timestamp overflow
    do_clear();
    set_in(1, 1, 0, 0); repeat (5) step(); set_in(0, 0, 0, 0);
    chk("t4_ovf", ts_ovf, 1);
    chk("t4_inflight", inflight, 4);
    // zero-latency bypass
    do_clear();
    set_in(1, 1, 1, 1); step(); set_in(0, 0, 0, 0);
    chk("t4_byp_valid", rec_valid, 1);
    chk("t4_byp_lat", rec_latency, 0);
    chk("t4_byp_inflight", inflight, 0);
    rec_ready = 1'b1; step(); rec_ready = 1'b0;

    // counter wrap
    do_clear();
    idle_until(8'd250);
    set_in(1, 1, 0, 0); step();
    idle_until(8'd4);
    set_in(0, 0, 1, 1); step(); set_in(0, 0, 0, 0);
    chk("t5_start", rec_start, 250);
    chk("t5_lat", rec_latency, 10);
    rec_ready = 1'b1; step(); rec_ready = 1'b0;

    // async reset mid-transaction, with a stored record
    do_clear();
    set_in(1, 1, 0, 0); step(); set_in(0, 0, 1, 1); step();
    set_in(1, 1, 0, 0); step(); set_in(0, 0, 0, 0); step();
    chk("t6_pre_level", rec_level, 1);
    ap_rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_valid", rec_valid, 0);
    chk("t6_rst_inflight", inflight, 0);
    chk("t6_rst_level", rec_level, 0);
    chk("t6_rst_start", rec_start, 0);
    step();
    ap_rst_n = 1'b1;
    set_in(0, 0, 1, 1); step(); set_in(0, 0, 0, 0);
    chk("t6_rst_orphan", orphan_err, 1);
    // same with synchronous clear
    do_clear();
    set_in(1, 1, 0, 0); step(); set_in(0, 0, 1, 1); step();
    set_in(1, 1, 0, 0); step(); set_in(0, 0, 0, 0);
    chk("t6_pre_inflight", inflight, 1);
    do_clear();
    chk("t6_clr_inflight", inflight, 0);
    chk("t6_clr_level", rec_level, 0);
    set_in(0, 0, 1, 1); step(); set_in(0, 0, 0, 0);
    chk("t6_clr_orphan", orphan_err, 1);

    // randomized traffic against the model
    do_clear();
    for (int i = 0; i < 4000; i++) begin
      enable          = ($urandom_range(0, 9) != 0);
      clear           = ($urandom_range(0, 299) == 0);
      mon_ap_start    = ($urandom_range(0, 2) == 0);
      mon_ap_ready    = ($urandom_range(0, 1) == 0);
      mon_ap_done     = ($urandom_range(0, 2) == 0);
      mon_ap_continue = ($urandom_range(0, 3) != 0);
      rec_ready       = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ap_handshake_profiler.md
# ap_handshake_profiler

Synthesizable per-block transaction profiler for the HLS-generated network's `ap_ctrl_hs` sub-blocks (dense and relu stages of `myproject`). It sits directly upstream of the simulation module-status monitor and CSV dump path. It observes one block's `ap_start`/`ap_ready`/`ap_done`/`ap_continue` and timestamps every transaction. For each completed transaction it emits one record (start time, latency, initiation interval) through a valid/ready FIFO, which the monitor or an on-chip readout drains.

## Interface
- `CNT_W`, 32: width of the cycle counter, timestamps, latency and interval fields.
- `TS_DEPTH`, 4: in-flight transactions tracked (power of 2, ≥2).
- `DEPTH`, 16: output record FIFO depth (power of 2, ≥2).
- `ap_clk`  in  1  single clock; all logic on rising edge.
- `ap_rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  capture enable; low = events ignored, cycle counter still runs.
- `clear`  in  1  synchronous clear; same effect as reset, priority over everything.
- `mon_ap_start`, `mon_ap_ready`, `mon_ap_done`, `mon_ap_continue`  in  1 each  observed handshake of the profiled block.
- `rec_valid`  out  1  output FIFO non-empty.
- `rec_ready`  in  1  consumer accepts the head record.
- `rec_start`  out  CNT_W  cycle-counter value at transaction start.
- `rec_latency`  out  CNT_W  done cycle minus start cycle (mod 2^CNT_W).
- `rec_interval`  out  CNT_W  this start minus previous start; 0 for the first start after reset/clear.
- `rec_level`  out  log2(DEPTH)+1  records currently stored.
- `drop_count`  out  16  records lost to a full FIFO, saturating at 16'hFFFF.
- `inflight`  out  log2(TS_DEPTH)+1  open transactions.
- `orphan_err`  out  1  sticky: done seen with no open transaction.
- `ts_ovf`  out  1  sticky: start seen with the timestamp FIFO full.

## Operation
- `cyc` is a free-running CNT_W counter: 0 after reset/clear, +1 every cycle, wraps modulo 2^CNT_W.
- Start detection uses flag `pend`, which means start is seen but not yet acknowledged by ready.
  - Start event: `enable & mon_ap_start & !pend`.
  - `pend` sets on a start event when `mon_ap_ready`=0.
  - `pend` clears on any cycle with `mon_ap_ready`=1.
  - Start with ready in the same cycle leaves `pend`=0, so an II=1 stream counts one start per cycle.
- On a start event, push `{cyc, cyc-prev_start}` into the timestamp FIFO and set `prev_start`=cyc. If the timestamp FIFO is full, set `ts_ovf` and drop the event; `prev_start` is not updated.
- Done event: `enable & mon_ap_done & mon_ap_continue`.
  - Pop the head timestamp and form a record with `latency = cyc - ts`.
  - If the timestamp FIFO is empty and a start event occurs in the same cycle, bypass: record latency 0, using this cycle's start and interval. The start is not stored.
  - If the timestamp FIFO is empty and there is no start: set `orphan_err` and produce no record.
- A start with a non-empty timestamp FIFO and a done in the same cycle does both: pop the head, push the new entry.
- Output FIFO is first-word fall-through; `rec_*` show the head whenever `rec_valid`=1.
  - Pop on `rec_valid & rec_ready`.
  - Record arriving while full: dropped and `drop_count` incremented, unless a pop occurs in the same cycle, in which case it is stored.
- Records leave in completion order; transactions complete in order (HLS blocks are in-order).

## Timing
- Reset/clear values: `cyc`=0, `rec_valid`=0, all `rec_*` data=0, `rec_level`=0, `drop_count`=0, `inflight`=0, `orphan_err`=0, `ts_ovf`=0, `pend`=0, `prev_start`=0, both FIFOs empty.
- Reset assertion clears all state immediately (asynchronous). Open transactions are discarded; stored records are lost.
- Start captured in cycle T → `ts`=T.
- Done captured in cycle D → record written at the end of D, `rec_valid` high in D+1.
- `rec_level` and `inflight` update one cycle after the event.
- `enable` falling with transactions open: open timestamps are kept. A done after `enable` returns still pops them.

## Test plan
- Single transaction: start high at cyc 10 until ready at cyc 14, done at cyc 14 → one record {start=10, latency=4, interval=0}; `rec_valid` at cyc 15.
- II=1 pipeline: start and ready high at cyc 20, 21, 22; dones at cyc 25, 26, 27 → records latency 5, 5, 5, intervals 0, 1, 1; `inflight` peaks at 3.
- Backpressure: `rec_ready`=0, 20 transactions with DEPTH=16 → `rec_level`=16, `drop_count`=4. Draining returns the first 16 in order. A push while full with a simultaneous pop is not dropped.
- Errors:
  - Done with nothing open → `orphan_err`=1, no record.
  - Five starts with no done, TS_DEPTH=4 → `ts_ovf`=1, `inflight`=4.
  - Start and done in the same cycle with the timestamp FIFO empty → latency 0 record.
- Wrap: CNT_W=8, start at cyc 250, done at cyc 4 after wrap → latency 10.
- Reset/clear mid-transaction: `ap_rst_n` low during an open transaction → all outputs 0 in the same cycle. A later done sets `orphan_err`. `clear` pulse gives identical results, synchronously.
